// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush scheduler for the 5-stage pipeline with mul/div and memory waits
module pipe_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W = 7,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_hazard,
  input  logic              control_hazard,
  input  logic              md_start,
  input  logic              md_done,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              md_go,
  output logic              keep_PC,
  output logic              keep_IF_ID,
  output logic              keep_ID_EX,
  output logic              keep_EX_MEM,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              flush_EX_MEM,
  output logic              flush_MEM_WB,
  output logic              md_err,
  output logic [PERF_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT} state_t;
  state_t fsm, nxt;
  logic [CNT_W-1:0] md_cnt;
  logic done_seen, mem_stall, done_now, at_limit, md_exit;
  assign mem_stall = mem_req && !mem_ready;
  assign done_now = md_done || done_seen;
  assign at_limit = md_cnt == CNT_W'(MD_TIMEOUT - 1);
  assign md_exit = fsm == MD_WAIT && (done_now || at_limit) && !mem_stall;
  // next state and keep/flush decode; memory freeze outranks everything, MEM_WAIT re-decodes like RUN
  always_comb begin
    nxt = fsm;
    {md_go, keep_PC, keep_IF_ID, keep_ID_EX, keep_EX_MEM, flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB} = 9'd0;
    if (rst)
      nxt = RUN;
    else if (mem_stall) begin
      {keep_PC, keep_IF_ID, keep_ID_EX, keep_EX_MEM, flush_MEM_WB} = 5'b11111;
      nxt = fsm == MD_WAIT ? MD_WAIT : MEM_WAIT;
    end else if (fsm == MD_WAIT) begin
      nxt = md_exit ? RUN : MD_WAIT;
      {keep_PC, keep_IF_ID, keep_ID_EX, flush_EX_MEM} = md_exit ? 4'b0000 : 4'b1111;
    end else begin
      nxt = md_start ? MD_WAIT : RUN;
      md_go = md_start;
      keep_PC = md_start || (!control_hazard && load_use_hazard);
      keep_IF_ID = keep_PC;
      keep_ID_EX = md_start;
      flush_EX_MEM = md_start;
      flush_IF_ID = !md_start && control_hazard;
      flush_ID_EX = !md_start && (control_hazard || load_use_hazard);
    end
  end
  // state, mul/div wait tracking, timeout pulse and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= RUN;
      md_cnt <= '0;
      done_seen <= 1'b0;
      md_err <= 1'b0;
      stall_cycles <= '0;
    end else begin
      fsm <= nxt;
      md_cnt <= fsm != MD_WAIT ? '0 : at_limit ? md_cnt : md_cnt + 1'b1;
      done_seen <= fsm == MD_WAIT && !md_exit && done_now;
      md_err <= md_exit && !done_now;
      stall_cycles <= stall_cycles + PERF_W'(keep_PC && !(&stall_cycles));
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of stall/flush scheduling, timeout and counter saturation
module tb_pipe_stall_ctrl;
  logic clk = 0, rst = 1;
  logic lu = 0, ch = 0, ms = 0, md = 0, mr = 0, mrdy = 0;
  logic [8:0] ctl, ctl4;
  logic err, err4;
  logic [31:0] stall;
  logic [2:0] stall4;
  int total = 0, bad = 0;
  localparam logic [8:0] NONE = 9'b0_0000_0000;
  localparam logic [8:0] LU   = 9'b0_1100_0100;
  localparam logic [8:0] CH   = 9'b0_0000_1100;
  localparam logic [8:0] GO   = 9'b1_1110_0010;
  localparam logic [8:0] MDH  = 9'b0_1110_0010;
  localparam logic [8:0] FRZ  = 9'b0_1111_0001;
  always #5 clk = ~clk;
  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .load_use_hazard(lu), .control_hazard(ch), .md_start(ms), .md_done(md),
    .mem_req(mr), .mem_ready(mrdy), .md_go(ctl[8]), .keep_PC(ctl[7]), .keep_IF_ID(ctl[6]),
    .keep_ID_EX(ctl[5]), .keep_EX_MEM(ctl[4]), .flush_IF_ID(ctl[3]), .flush_ID_EX(ctl[2]),
    .flush_EX_MEM(ctl[1]), .flush_MEM_WB(ctl[0]), .md_err(err), .stall_cycles(stall)
  );
  pipe_stall_ctrl #(.MD_TIMEOUT(4), .CNT_W(2), .PERF_W(3)) dut4 (
    .clk(clk), .rst(rst), .load_use_hazard(lu), .control_hazard(ch), .md_start(ms), .md_done(md),
    .mem_req(mr), .mem_ready(mrdy), .md_go(ctl4[8]), .keep_PC(ctl4[7]), .keep_IF_ID(ctl4[6]),
    .keep_ID_EX(ctl4[5]), .keep_EX_MEM(ctl4[4]), .flush_IF_ID(ctl4[3]), .flush_ID_EX(ctl4[2]),
    .flush_EX_MEM(ctl4[1]), .flush_MEM_WB(ctl4[0]), .md_err(err4), .stall_cycles(stall4)
  );
  task automatic set(input logic r, a, b, c, d, e, f);
    @(posedge clk);
    #1;
    {rst, lu, ch, ms, md, mr, mrdy} = {r, a, b, c, d, e, f};
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    set(1, 1, 1, 1, 1, 1, 0);
    chk("rst_ctl", ctl, NONE);
    set(1, 1, 1, 1, 1, 1, 0);
    chk("rst_ctl2", ctl, NONE);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("idle_ctl", ctl, NONE);
    chk("idle_err", err, 0);
    chk("idle_stall", stall, 0);
    set(0, 1, 0, 0, 0, 0, 0);
    chk("lu_ctl", ctl, LU);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("lu_off", ctl, NONE);
    chk("lu_stall", stall, 1);
    set(0, 1, 1, 0, 0, 0, 0);
    chk("ch_lu_ctl", ctl, CH);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("ch_stall", stall, 1);
    set(0, 0, 0, 1, 0, 0, 0);
    chk("md_go", ctl, GO);
    set(0, 0, 0, 1, 0, 0, 0);
    chk("md_no_repulse", ctl, MDH);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("md_hold2", ctl, MDH);
    set(0, 1, 1, 0, 0, 0, 0);
    chk("md_ign_haz", ctl, MDH);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("md_hold4", ctl, MDH);
    set(0, 0, 0, 0, 1, 0, 0);
    chk("md_exit", ctl, NONE);
    set(0, 1, 0, 0, 0, 0, 0);
    chk("md_back_run", ctl, LU);
    chk("md_stall", stall, 6);
    chk("md_err_none", err, 0);
    set(0, 0, 0, 1, 0, 0, 0);
    chk("mw_go", ctl, GO);
    chk("mw_stall0", stall, 7);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("mw_hold", ctl, MDH);
    set(0, 0, 0, 0, 0, 1, 0);
    chk("mw_frz1", ctl, FRZ);
    set(0, 0, 0, 0, 1, 1, 0);
    chk("mw_frz2", ctl, FRZ);
    set(0, 0, 0, 0, 0, 1, 0);
    chk("mw_frz3", ctl, FRZ);
    set(0, 0, 0, 0, 0, 1, 1);
    chk("mw_exit", ctl, NONE);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("mw_run", ctl, NONE);
    chk("mw_err", err, 0);
    chk("mw_stall", stall, 12);
    set(0, 0, 0, 1, 0, 1, 0);
    chk("run_frz_nogo", ctl, FRZ);
    set(0, 0, 0, 1, 0, 1, 1);
    chk("memwait_go", ctl, GO);
    set(0, 0, 0, 0, 1, 0, 0);
    chk("memwait_md_exit", ctl, NONE);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("memwait_stall", stall, 14);
    set(1, 0, 0, 0, 0, 0, 0);
    set(0, 0, 0, 1, 0, 0, 0);
    chk("to_go", ctl4, GO);
    for (int i = 0; i < 3; i++) begin
      set(0, 0, 0, 1, 0, 0, 0);
      chk("to_hold", ctl4, MDH);
    end
    set(0, 0, 0, 1, 0, 0, 0);
    chk("to_exit", ctl4, NONE);
    chk("to_err_early", err4, 0);
    set(0, 0, 0, 1, 0, 0, 0);
    chk("to_err", err4, 1);
    chk("to_rego", ctl4, GO);
    chk("to_stall", stall4, 4);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("to_err_once", err4, 0);
    for (int i = 0; i < 2; i++) begin
      set(0, 0, 0, 0, 0, 0, 0);
      chk("to_hold2", ctl4, MDH);
    end
    set(0, 0, 0, 0, 0, 0, 0);
    chk("to_exit2", ctl4, NONE);
    chk("sat_stall", stall4, 7);
    set(0, 0, 0, 1, 0, 0, 0);
    chk("to_err2", err4, 1);
    chk("sat_go", ctl4, GO);
    set(1, 0, 0, 1, 0, 0, 0);
    chk("midrst_ctl4", ctl4, NONE);
    chk("midrst_ctl", ctl, NONE);
    set(0, 0, 0, 0, 0, 0, 0);
    chk("postrst_ctl4", ctl4, NONE);
    chk("postrst_stall4", stall4, 0);
    chk("postrst_err4", err4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
